// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S speaker transmit path.
//   - Frame geometry: 64-bit frame, two 32-bit slots, word select leading
//     each slot by one bit.
//   - sample_t: signed 16-bit audio sample.
//   - bit_idx_t: bit position within a frame (0..63).
//   - ws_for_bit(): word-select level for a given bit index.
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int WS_LEAD    = 1;

  typedef logic signed [15:0] sample_t;
  typedef logic [5:0]         bit_idx_t;

  localparam bit_idx_t BIT_IDX_LAST = bit_idx_t'(FRAME_BITS - 1);

  // ws rises one bit before the right slot and falls one bit before the next
  // frame, so it is high for b = 31..62.
  function automatic logic ws_for_bit(input bit_idx_t b);
    return (b >= bit_idx_t'(SLOT_BITS - WS_LEAD)) &&
           (b <= bit_idx_t'(FRAME_BITS - 1 - WS_LEAD));
  endfunction

endpackage

// File: rtl/i2s_tx_clkgen.sv
// i2s_tx_clkgen: I2S bit-clock generator.
//   Divides clk_i by 2*CLK_DIV to produce sck_o and flags the cycle on which
//   sck_o is about to fall, so downstream registers can update on that edge.
// Ports:
//   clk_i       system clock
//   rst_ni      synchronous reset, active-low
//   sck_o       bit clock (registered)
//   fall_evt_o  one-cycle strobe: the next clk_i edge drives sck_o 1 -> 0
module i2s_tx_clkgen #(
  parameter int CLK_DIV = 24
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sck_o,
  output logic fall_evt_o
);

  localparam int                CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             sck_q, sck_d;
  logic             tc_s;

  // Divider next state: wrap at terminal count and toggle sck there.
  always_comb begin
    tc_s       = (div_cnt_q == CNT_LAST);
    div_cnt_d  = div_cnt_q;
    sck_d      = sck_q;
    // Strobe is combinational so the consumer updates on the same edge
    // that drives sck low.
    fall_evt_o = tc_s & sck_q;
    if (tc_s) begin
      div_cnt_d = '0;
      sck_d     = ~sck_q;
    end else begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end
  end

  // Divider and sck state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/i2s_speaker_tx.sv
// i2s_speaker_tx: I2S controller-mode transmitter for the speaker/DAC path.
//   Takes signed mono samples over valid/ready into a 1-entry holding
//   register and sends each one on both slots of a 64-bit I2S frame.
//   If no sample is held when a frame starts, the frame carries zeros and
//   underrun pulses for one cycle.
// Optional build macro: I2S_TX_VOLUME_EN adds vol_shift, an arithmetic
//   right shift applied when the held sample is loaded at frame start.
// Ports:
//   clk_in       system clock (98.304 MHz nominal)
//   rst_n_in     synchronous reset, active-low
//   audio_data   signed sample, captured on valid && ready
//   audio_valid  sample valid
//   audio_ready  holding register empty (forced low during reset)
//   spk_sck      I2S bit clock
//   spk_ws       I2S word select (0 = left, 1 = right)
//   spk_sd       I2S serial data, MSB first
//   underrun     one-cycle pulse when a frame starts with nothing held
//   vol_shift    (I2S_TX_VOLUME_EN only) attenuation shift, 0..15
module i2s_speaker_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV      = 24,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [15:0] audio_data,
  input  logic        audio_valid,
  output logic        audio_ready,
  output logic        spk_sck,
  output logic        spk_ws,
  output logic        spk_sd,
  output logic        underrun
`ifdef I2S_TX_VOLUME_EN
  ,
  input  logic [3:0]  vol_shift
`endif
);

  bit_idx_t b_q, b_d, b_nxt_s;
  logic     ws_q, ws_d;
  logic     sd_q, sd_d;
  logic     und_q, und_d;
  logic     hold_full_q, hold_full_d;
  sample_t  hold_q, hold_d;
  sample_t  frame_q, frame_d;
  logic     fall_evt_s, frame_start_s, xfer_s;
  logic [4:0] pos_s;
  logic [3:0] sd_idx_s;

  i2s_tx_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .sck_o      (spk_sck),
    .fall_evt_o (fall_evt_s)
  );

  assign audio_ready = rst_n_in & ~hold_full_q;

  // Frame sequencing, serializer and holding-register next state.
  always_comb begin
    b_d           = b_q;
    ws_d          = ws_q;
    sd_d          = sd_q;
    und_d         = 1'b0;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    frame_d       = frame_q;
    b_nxt_s       = b_q + 6'd1;
    pos_s         = b_nxt_s[4:0];
    sd_idx_s      = 4'(SAMPLE_WIDTH - int'(pos_s));
    xfer_s        = audio_valid & audio_ready;
    frame_start_s = fall_evt_s && (b_q == BIT_IDX_LAST);

    if (fall_evt_s) begin
      b_d  = b_nxt_s;
      ws_d = ws_for_bit(b_nxt_s);
      // Slot bit 0 is the one-bit I2S delay; data occupies positions
      // 1..SAMPLE_WIDTH, the rest of the slot is padded with zeros.
      if ((pos_s != 5'd0) && (int'(pos_s) <= SAMPLE_WIDTH)) begin
        sd_d = frame_q[sd_idx_s];
      end else begin
        sd_d = 1'b0;
      end
    end else begin
      b_d = b_q;
    end

    if (frame_start_s) begin
      if (hold_full_q) begin
`ifdef I2S_TX_VOLUME_EN
        frame_d = hold_q >>> vol_shift;
`else
        frame_d = hold_q;
`endif
        hold_full_d = 1'b0;
      end else begin
        frame_d = '0;
        und_d   = 1'b1;
      end
    end else begin
      und_d = 1'b0;
    end

    // A transfer only happens with hold empty, so it never collides with the
    // frame-start consume above; a same-cycle accept waits for the next frame.
    if (xfer_s) begin
      hold_d      = sample_t'(audio_data);
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_d;
    end
  end

  // State registers; reset aborts any frame in progress and drops the hold.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      b_q         <= BIT_IDX_LAST;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      und_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      frame_q     <= '0;
    end else begin
      b_q         <= b_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      und_q       <= und_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      frame_q     <= frame_d;
    end
  end

  assign spk_ws   = ws_q;
  assign spk_sd   = sd_q;
  assign underrun = und_q;

endmodule

// File: tb/tb_i2s_speaker_tx.sv
// Testbench for i2s_speaker_tx. A reference model derives the expected
// waveform from the time elapsed since reset release and tracks the
// one-deep sample hold; every cycle the DUT outputs are compared with it.
// Directed phases cover idle underrun, a single sample, back-to-back
// samples, accept on the frame-start cycle and reset mid-frame; a random
// phase follows. Build with I2S_TX_VOLUME_EN to cover vol_shift.
module tb_i2s_speaker_tx;

  localparam int CLK_DIV = 24;
  localparam int BIT_CYC = 2 * CLK_DIV;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [15:0] audio_data = 16'h0000;
  logic        audio_valid = 1'b0;
  logic        audio_ready;
  logic        spk_sck, spk_ws, spk_sd, underrun;
`ifdef I2S_TX_VOLUME_EN
  logic [3:0]  vol_shift = 4'd0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int                 t = 0;      // clk_in edges since reset release
  int                 nfs = 0;    // frame starts seen
  logic               m_full = 1'b0;
  logic               m_und = 1'b0;
  logic               m_xfer;
  logic signed [15:0] m_hold = 16'sd0;
  logic signed [15:0] m_frame = 16'sd0;
  logic               chk_en = 1'b0;
  int                 c_b, c_p;
  logic               c_sd;
  logic [15:0]        left_w = 16'h0000;
  logic [15:0]        right_w = 16'h0000;
  logic [15:0]        saved;

  i2s_speaker_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_WIDTH(16)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .audio_data  (audio_data),
    .audio_valid (audio_valid),
    .audio_ready (audio_ready),
    .spk_sck     (spk_sck),
    .spk_ws      (spk_ws),
    .spk_sd      (spk_sd),
    .underrun    (underrun)
`ifdef I2S_TX_VOLUME_EN
    ,
    .vol_shift   (vol_shift)
`endif
  );

  initial forever #5 clk_in = ~clk_in;

  function automatic int exp_b(input int tt);
    return (63 + tt / BIT_CYC) % 64;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // reference model: advances on every clk_in edge
  initial forever begin
    @(posedge clk_in);
    if (!rst_n_in) begin
      t = 0; m_full = 1'b0; m_hold = 16'sd0; m_frame = 16'sd0; m_und = 1'b0;
    end else begin
      m_xfer = audio_valid && !m_full;
      t = t + 1;
      m_und = 1'b0;
      if ((t % BIT_CYC == 0) && (exp_b(t) == 0)) begin
        nfs++;
        if (m_full) begin
`ifdef I2S_TX_VOLUME_EN
          m_frame = m_hold >>> vol_shift;
`else
          m_frame = m_hold;
`endif
          m_full = 1'b0;
        end else begin
          m_frame = 16'sd0;
          m_und = 1'b1;
        end
      end
      if (m_xfer) begin
        m_hold = audio_data;
        m_full = 1'b1;
      end
    end
  end

  // per-cycle comparison and slot-word capture, away from the active edge
  initial forever begin
    @(negedge clk_in);
    if (chk_en) begin
      c_b = exp_b(t);
      c_p = c_b % 32;
      c_sd = ((c_p >= 1) && (c_p <= 16)) ? m_frame[16 - c_p] : 1'b0;
      check_eq("sck", {31'd0, spk_sck}, (t / CLK_DIV) % 2);
      check_eq("ws", {31'd0, spk_ws}, ((c_b >= 31) && (c_b <= 62)) ? 1 : 0);
      check_eq("sd", {31'd0, spk_sd}, {31'd0, c_sd});
      check_eq("underrun", {31'd0, underrun}, {31'd0, m_und});
      check_eq("ready", {31'd0, audio_ready}, {31'd0, rst_n_in && !m_full});
      if (c_b >= 1 && c_b <= 16) left_w[16 - c_b] = spk_sd;
      if (c_b >= 33 && c_b <= 48) right_w[48 - c_b] = spk_sd;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    int i;
    i = 0;
    audio_data = d;
    audio_valid = 1'b1;
    while (!audio_ready && i < 8000) begin
      @(negedge clk_in); #1; i++;
    end
    check_eq("push_wait", {31'd0, (i < 8000)}, 32'd1);
    @(negedge clk_in); #1;
    audio_valid = 1'b0;
  endtask

  task automatic wait_b(input int target);
    int i;
    i = 0;
    while (exp_b(t) != target && i < 4000) begin
      @(negedge clk_in); #1; i++;
    end
    check_eq("wait_b", {31'd0, (i < 4000)}, 32'd1);
  endtask

  task automatic wait_frames(input int n);
    int target, i;
    target = nfs + n;
    i = 0;
    while (nfs < target && i < n * 3072 + 200) begin
      @(negedge clk_in); #1; i++;
    end
    check_eq("wait_frames", {31'd0, (nfs >= target)}, 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  initial begin
    int i;
    repeat (3) @(negedge clk_in);
    chk_en = 1'b1;
    check_eq("rst_sck", {31'd0, spk_sck}, 32'd0);
    check_eq("rst_ws", {31'd0, spk_ws}, 32'd0);
    check_eq("rst_sd", {31'd0, spk_sd}, 32'd0);
    check_eq("rst_underrun", {31'd0, underrun}, 32'd0);
    check_eq("rst_ready", {31'd0, audio_ready}, 32'd0);
    #1;
    rst_n_in = 1'b1;

    // idle: zeros and an underrun every frame
    wait_frames(3);
    check_eq("t1_underrun", {31'd0, underrun}, 32'd1);

    // single sample right after reset
    pulse_reset();
    push(16'hA5C3);
    wait_b(50);
    check_eq("t2_left", {16'd0, left_w}, 32'h0000A5C3);
    check_eq("t2_right", {16'd0, right_w}, 32'h0000A5C3);

    // valid held high across three samples
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    wait_frames(1);
    wait_b(50);
    check_eq("t3_left", {16'd0, left_w}, 32'h00000003);

    // single-cycle valid on the frame-start edge with hold empty
    i = 0;
    while (!(!m_full && ((t + 1) % BIT_CYC == 0) && (exp_b(t + 1) == 0)) && i < 8000) begin
      @(negedge clk_in); #1; i++;
    end
    check_eq("t4_align", {31'd0, (i < 8000)}, 32'd1);
    saved = 16'($urandom);
    audio_data = saved;
    audio_valid = 1'b1;
    @(negedge clk_in);
    check_eq("t4_underrun", {31'd0, underrun}, 32'd1);
    #1;
    audio_valid = 1'b0;
    wait_frames(1);
    wait_b(50);
    check_eq("t4_next", {16'd0, left_w}, {16'd0, saved});

    // reset mid-frame with the hold full
    wait_b(5);
    push(16'($urandom));
    wait_b(20);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    check_eq("t5_sck", {31'd0, spk_sck}, 32'd0);
    check_eq("t5_ws", {31'd0, spk_ws}, 32'd0);
    check_eq("t5_sd", {31'd0, spk_sd}, 32'd0);
    check_eq("t5_underrun", {31'd0, underrun}, 32'd0);
    check_eq("t5_ready", {31'd0, audio_ready}, 32'd0);
    #1;
    rst_n_in = 1'b1;
    wait_frames(1);
    check_eq("t5_first_underrun", {31'd0, underrun}, 32'd1);

`ifdef I2S_TX_VOLUME_EN
    // attenuation applied at frame-sample load
    vol_shift = 4'd4;
    push(16'h8000);
    wait_frames(1);
    wait_b(50);
    check_eq("t6_vol4", {16'd0, left_w}, 32'h0000F800);
    vol_shift = 4'd0;
    push(16'h8000);
    wait_frames(1);
    wait_b(50);
    check_eq("t6_vol0", {16'd0, left_w}, 32'h00008000);
`endif

    // random traffic with random gaps
    repeat (6) begin
      idle($urandom_range(0, 3000));
`ifdef I2S_TX_VOLUME_EN
      vol_shift = 4'($urandom_range(0, 15));
`endif
      push(16'($urandom));
    end
    wait_frames(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
